safety_error_dispatcher: RTL and testbench

//   Collects error events from NUM_SRC safety monitors (lockstep, ECC, watchdog, ...).

---
 rtl/safety_error_dispatcher.sv | 94 +++++++++
 tb/tb_safety_error_dispatcher.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/safety_error_dispatcher.sv
// safety_error_dispatcher: round-robin error collector with event FIFO, sticky overflow and head-timeout escalation
module safety_error_dispatcher #(
  parameter int NUM_SRC     = 4,
  parameter int CODE_W      = 32,
  parameter int FIFO_DEPTH  = 8,
  parameter int ESC_TIMEOUT = 1024
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [NUM_SRC-1:0]              src_valid_i,
  input  logic [NUM_SRC*CODE_W-1:0]       src_code_i,
  output logic [NUM_SRC-1:0]              src_ready_o,
  output logic                            err_valid_o,
  output logic [CODE_W-1:0]               err_code_o,
  output logic [$clog2(NUM_SRC)-1:0]      err_src_o,
  input  logic                            err_ready_i,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_count_o,
  output logic                            overflow_o,
  output logic                            escalate_o,
  input  logic                            clear_i
);
  localparam int SRC_W = $clog2(NUM_SRC);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int AGE_W = $clog2(ESC_TIMEOUT);
  localparam logic [AGE_W-1:0] AGE_MAX  = AGE_W'(ESC_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ESC} state_t;
  logic [SRC_W+CODE_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [SRC_W-1:0] rr_ptr, gnt_idx;
  logic [CNT_W-1:0] cnt_nxt;
  logic [AGE_W-1:0] age;
  logic found, full, push, pop;
  state_t state;
  always_comb begin
    found = 1'b0;
    gnt_idx = '0;
    for (int i = 0; i < NUM_SRC; i++)
      if (!found && src_valid_i[SRC_W'((int'(rr_ptr) + i) % NUM_SRC)]) begin
        found = 1'b1;
        gnt_idx = SRC_W'((int'(rr_ptr) + i) % NUM_SRC);
      end
  end
  assign full        = fifo_count_o == FULL_CNT;
  assign src_ready_o = (found && !full && !rst_i) ? NUM_SRC'(1) << gnt_idx : '0;
  assign push        = |src_ready_o;
  assign err_valid_o = fifo_count_o != '0;
  assign pop         = err_valid_o & err_ready_i;
  assign cnt_nxt     = fifo_count_o + CNT_W'(push) - CNT_W'(pop);
  assign {err_src_o, err_code_o} = mem[rd_ptr];
  always_ff @(posedge clk_i)
    if (push) mem[wr_ptr] <= {gnt_idx, src_code_i[gnt_idx*CODE_W +: CODE_W]};
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      rr_ptr       <= '0;
      fifo_count_o <= '0;
      overflow_o   <= 1'b0;
      escalate_o   <= 1'b0;
      age          <= '0;
      state        <= ST_IDLE;
    end else begin
      wr_ptr       <= wr_ptr + PTR_W'(push);
      rd_ptr       <= rd_ptr + PTR_W'(pop);
      fifo_count_o <= cnt_nxt;
      if (push) rr_ptr <= gnt_idx == SRC_W'(NUM_SRC - 1) ? '0 : gnt_idx + 1'b1;
      overflow_o <= (|src_valid_i && full) | (overflow_o & ~clear_i);
      case (state)
        ST_IDLE:
          if (err_valid_o) begin
            state <= (pop && cnt_nxt == '0) ? ST_IDLE : ST_WAIT;
            age   <= pop ? '0 : AGE_W'(1);
          end
        ST_WAIT:
          if (pop) begin
            age   <= '0;
            state <= cnt_nxt == '0 ? ST_IDLE : ST_WAIT;
          end else if (age == AGE_MAX) begin
            state      <= ST_ESC;
            escalate_o <= 1'b1;
          end else age <= age + 1'b1;
        ST_ESC:
          if (clear_i) begin
            escalate_o <= 1'b0;
            age        <= '0;
            state      <= cnt_nxt == '0 ? ST_IDLE : ST_WAIT;
          end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_safety_error_dispatcher.sv
// tb_safety_error_dispatcher: directed stimulus with an expected-event queue checked by a pop monitor
module tb_safety_error_dispatcher;
  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic [3:0]  src_valid_i = 4'b1111;
  logic [127:0] src_code_i = '0;
  logic [3:0]  src_ready_o;
  logic        err_valid_o;
  logic [31:0] err_code_o;
  logic [1:0]  err_src_o;
  logic        err_ready_i = 1'b0;
  logic [3:0]  fifo_count_o;
  logic        overflow_o;
  logic        escalate_o;
  logic        clear_i = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [33:0] exp_q [$];
  safety_error_dispatcher #(.NUM_SRC(4), .CODE_W(32), .FIFO_DEPTH(8), .ESC_TIMEOUT(16)) dut (
    .clk_i(clk), .rst_i(rst_i), .src_valid_i(src_valid_i), .src_code_i(src_code_i),
    .src_ready_o(src_ready_o), .err_valid_o(err_valid_o), .err_code_o(err_code_o),
    .err_src_o(err_src_o), .err_ready_i(err_ready_i), .fifo_count_o(fifo_count_o),
    .overflow_o(overflow_o), .escalate_o(escalate_o), .clear_i(clear_i)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, act, exp);
    end
  endtask
  task automatic nx;
    @(posedge clk);
    #1;
  endtask
  task automatic mid;
    @(negedge clk);
  endtask
  task automatic expect_ev(input int src, input logic [31:0] code);
    exp_q.push_back({2'(src), code});
  endtask
  always @(negedge clk)
    if (!rst_i && err_valid_o && err_ready_i) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected got src=%0d code=%0h expected none", err_src_o, err_code_o);
      end else begin
        logic [33:0] e;
        e = exp_q.pop_front();
        if ({err_src_o, err_code_o} !== e) begin
          errors++;
          $display("FAIL pop_event got src=%0d code=%0h expected src=%0d code=%0h",
                   err_src_o, err_code_o, e[33:32], e[31:0]);
        end
      end
    end
  initial begin
    nx;
    nx;
    mid;
    chk("rst_ready", 32'(src_ready_o), 0);
    chk("rst_valid", 32'(err_valid_o), 0);
    chk("rst_count", 32'(fifo_count_o), 0);
    chk("rst_ovf", 32'(overflow_o), 0);
    chk("rst_esc", 32'(escalate_o), 0);
    nx;
    rst_i = 1'b0;
    src_valid_i = 4'b0100;
    src_code_i[64 +: 32] = 32'hDEAD_0002;
    mid;
    chk("t1_ready", 32'(src_ready_o), 32'b0100);
    expect_ev(2, 32'hDEAD_0002);
    nx;
    src_valid_i = '0;
    mid;
    chk("t1_valid", 32'(err_valid_o), 1);
    chk("t1_code", err_code_o, 32'hDEAD_0002);
    chk("t1_src", 32'(err_src_o), 2);
    chk("t1_count", 32'(fifo_count_o), 1);
    nx;
    err_ready_i = 1'b1;
    nx;
    err_ready_i = 1'b0;
    mid;
    chk("t1_drained", 32'(fifo_count_o), 0);
    nx;
    rst_i = 1'b1;
    nx;
    rst_i = 1'b0;
    for (int k = 0; k < 4; k++) src_code_i[k*32 +: 32] = 32'hC0DE_0000 + 32'(k);
    src_valid_i = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      mid;
      chk($sformatf("t2_grant%0d", i), 32'(src_ready_o), 32'(1) << (i % 4));
      expect_ev(i % 4, 32'hC0DE_0000 + 32'(i % 4));
      nx;
    end
    mid;
    chk("t2_count", 32'(fifo_count_o), 8);
    chk("t2_noready", 32'(src_ready_o), 0);
    chk("t2_noovf_yet", 32'(overflow_o), 0);
    nx;
    src_valid_i = 4'b0001;
    mid;
    chk("t3_ovf", 32'(overflow_o), 1);
    nx;
    clear_i = 1'b1;
    nx;
    clear_i = 1'b0;
    mid;
    chk("t3_set_wins", 32'(overflow_o), 1);
    nx;
    src_valid_i = '0;
    clear_i = 1'b1;
    nx;
    clear_i = 1'b0;
    mid;
    chk("t3_cleared", 32'(overflow_o), 0);
    nx;
    err_ready_i = 1'b1;
    repeat (8) nx;
    err_ready_i = 1'b0;
    mid;
    chk("t2_drained", 32'(fifo_count_o), 0);
    chk("t2_no_esc", 32'(escalate_o), 0);
    nx;
    src_valid_i = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      src_code_i[32 +: 32] = 32'h4000_000A + 32'(i);
      mid;
      chk($sformatf("t4_fill%0d", i), 32'(src_ready_o), 32'b0010);
      expect_ev(1, 32'h4000_000A + 32'(i));
      nx;
    end
    src_code_i[32 +: 32] = 32'h4000_000D;
    err_ready_i = 1'b1;
    mid;
    chk("t4_count_before", 32'(fifo_count_o), 3);
    chk("t4_ready", 32'(src_ready_o), 32'b0010);
    expect_ev(1, 32'h4000_000D);
    nx;
    src_valid_i = '0;
    err_ready_i = 1'b0;
    mid;
    chk("t4_count_after", 32'(fifo_count_o), 3);
    nx;
    err_ready_i = 1'b1;
    repeat (3) nx;
    err_ready_i = 1'b0;
    mid;
    chk("t4_drained", 32'(fifo_count_o), 0);
    nx;
    src_valid_i = 4'b1000;
    src_code_i[96 +: 32] = 32'hE5C0_0003;
    expect_ev(3, 32'hE5C0_0003);
    nx;
    src_valid_i = '0;
    mid;
    chk("t5_valid", 32'(err_valid_o), 1);
    for (int j = 0; j < 16; j++) begin
      if (j > 0) mid;
      chk($sformatf("t5_noesc%0d", j), 32'(escalate_o), 0);
      nx;
    end
    mid;
    chk("t5_esc", 32'(escalate_o), 1);
    nx;
    clear_i = 1'b1;
    err_ready_i = 1'b1;
    nx;
    clear_i = 1'b0;
    err_ready_i = 1'b0;
    mid;
    chk("t5_esc_cleared", 32'(escalate_o), 0);
    chk("t5_drained", 32'(fifo_count_o), 0);
    nx;
    src_valid_i = 4'b0001;
    src_code_i[0 +: 32] = 32'hF00D_0000;
    expect_ev(0, 32'hF00D_0000);
    nx;
    src_valid_i = '0;
    repeat (15) nx;
    err_ready_i = 1'b1;
    nx;
    err_ready_i = 1'b0;
    repeat (4) begin
      mid;
      chk("t5_pop15_noesc", 32'(escalate_o), 0);
      nx;
    end
    src_valid_i = 4'b1111;
    repeat (5) nx;
    src_valid_i = '0;
    mid;
    chk("t6_count5", 32'(fifo_count_o), 5);
    for (int j = 0; j < 40 && !escalate_o; j++) nx;
    mid;
    chk("t6_esc", 32'(escalate_o), 1);
    nx;
    rst_i = 1'b1;
    src_valid_i = 4'b0110;
    exp_q.delete();
    mid;
    chk("t6_rst_ready", 32'(src_ready_o), 0);
    nx;
    mid;
    chk("t6_valid", 32'(err_valid_o), 0);
    chk("t6_count", 32'(fifo_count_o), 0);
    chk("t6_ovf", 32'(overflow_o), 0);
    chk("t6_esc0", 32'(escalate_o), 0);
    nx;
    rst_i = 1'b0;
    src_code_i[32 +: 32] = 32'h6000_0001;
    mid;
    chk("t6_grant", 32'(src_ready_o), 32'b0010);
    expect_ev(1, 32'h6000_0001);
    nx;
    src_valid_i = '0;
    err_ready_i = 1'b1;
    nx;
    err_ready_i = 1'b0;
    mid;
    chk("t6_drained", 32'(fifo_count_o), 0);
    chk("queue_empty", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
